// File: rtl/rb_sync_ecc.sv
// Single-clock first-word-fall-through read buffer: RAM with registered read feeding a head register.
// Optional per-lane SECDED storage protection and ErrInj port when RB_SYNC_ECC_EN is defined.

`ifdef RB_SYNC_ECC_EN
module rb_sync_ecc_lane #(
    parameter int LANE_W = 64,
    parameter int CB     = 8
) (
    input  logic [LANE_W-1:0] wdata,
    output logic [CB-1:0]     wchk,
    input  logic [LANE_W-1:0] rdata,
    input  logic [CB-1:0]     rchk,
    output logic [LANE_W-1:0] cdata,
    output logic              se,
    output logic              de
);
    localparam int R    = CB - 1;
    localparam int MAXP = LANE_W + R;

    // Hamming position of data bit i: the i-th position >= 3 that is not a power of two.
    function automatic int dpos(input int i);
        int p;
        int n;
        p = 2;
        n = -1;
        while (n < i) begin
            p++;
            if ((p & (p - 1)) != 0) n++;
        end
        return p;
    endfunction

    logic [LANE_W-1:0][R-1:0] pos;
    for (genvar i = 0; i < LANE_W; i++) begin : g_pos
        assign pos[i] = R'(dpos(i));
    end

    logic [R-1:0] wsyn;
    logic [R-1:0] rsyn;
    logic [R-1:0] syn;

    always_comb begin
        wsyn = '0;
        rsyn = '0;
        for (int i = 0; i < LANE_W; i++) begin
            for (int j = 0; j < R; j++) begin
                if (pos[i][j]) begin
                    wsyn[j] = wsyn[j] ^ wdata[i];
                    rsyn[j] = rsyn[j] ^ rdata[i];
                end
            end
        end
    end

    // Top check bit is overall parity over data and Hamming bits.
    assign wchk = {^{wdata, wsyn}, wsyn};

    always_comb begin
        syn   = rchk[R-1:0] ^ rsyn;
        cdata = rdata;
        se    = 1'b0;
        de    = 1'b0;
        if (^{rdata, rchk}) begin
            if (int'(syn) > MAXP) begin
                de = 1'b1;
            end else begin
                se = 1'b1;
                for (int i = 0; i < LANE_W; i++) begin
                    if (syn == pos[i]) cdata[i] = ~rdata[i];
                end
            end
        end else if (syn != '0) begin
            de = 1'b1;
        end
    end
endmodule
`endif

module rb_sync_ecc #(
    parameter int LANES       = 2,
    parameter int LANE_W      = 64,
    parameter int DEPTH       = 512,
    parameter int AFULL_LEVEL = 384,
    parameter int CNT_W       = 16
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [LANES*LANE_W-1:0]   MD,
    input  logic                      WRen,
    output logic                      Full,
    output logic [LANES*LANE_W-1:0]   RD,
    input  logic                      RDen,
    output logic                      Empty,
    output logic                      SingleError,
    output logic                      DoubleError,
    output logic [$clog2(DEPTH):0]    Level,
    output logic                      Overflow,
    output logic                      Underflow,
    output logic [CNT_W-1:0]          SECount,
    output logic [CNT_W-1:0]          DECount
`ifdef RB_SYNC_ECC_EN
    ,
    input  logic [1:0]                ErrInj
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = LANES * LANE_W;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

`ifdef RB_SYNC_ECC_EN
    function automatic int secded_cb(input int w);
        int r;
        r = 1;
        while ((1 << r) < w + r + 1) r++;
        return r + 1;
    endfunction

    localparam int CB    = secded_cb(LANE_W);
    localparam int SW    = LANE_W + CB;
    localparam int MEM_W = LANES * SW;
`else
    localparam int MEM_W = DW;
`endif

    logic [MEM_W-1:0] wword;
    logic [MEM_W-1:0] rdata_q;
    logic [DW-1:0]    dec_data;
    logic             dec_se;
    logic             dec_de;

`ifdef RB_SYNC_ECC_EN
    logic [LANES-1:0] lane_se;
    logic [LANES-1:0] lane_de;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [CB-1:0]     wchk;
        logic [LANE_W-1:0] inj;
        // Injected flips land on stored data only, after the check bits are computed.
        assign inj = (g == 0) ? {{(LANE_W-2){1'b0}}, ErrInj} : '0;
        rb_sync_ecc_lane #(.LANE_W(LANE_W), .CB(CB)) u_lane (
            .wdata (MD[g*LANE_W +: LANE_W]),
            .wchk  (wchk),
            .rdata (rdata_q[g*SW +: LANE_W]),
            .rchk  (rdata_q[g*SW+LANE_W +: CB]),
            .cdata (dec_data[g*LANE_W +: LANE_W]),
            .se    (lane_se[g]),
            .de    (lane_de[g])
        );
        assign wword[g*SW +: SW] = {wchk, MD[g*LANE_W +: LANE_W] ^ inj};
    end
    assign dec_de = |lane_de;
    assign dec_se = |lane_se & ~dec_de;
`else
    assign wword    = MD;
    assign dec_data = rdata_q;
    assign dec_se   = 1'b0;
    assign dec_de   = 1'b0;
`endif

    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]    ram_cnt_q, ram_cnt_d, level_q, level_d;
    logic             ram_vld_q, ram_vld_d, head_vld_q, head_vld_d;
    logic [DW-1:0]    head_q, head_d;
    logic             se_q, se_d, de_q, de_d, ovf_q, ovf_d, unf_q, unf_d;
    logic [CNT_W-1:0] sec_q, sec_d, dec_q, dec_d;
    logic             pop, push, head_ld, rd_issue;

    logic [MEM_W-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (push) mem[wptr_q] <= wword;
        if (rd_issue) rdata_q <= mem[rptr_q];
    end

    // ram_cnt counts words still in RAM; the read stage and head register each hold one more.
    always_comb begin
        pop      = RDen && head_vld_q;
        push     = WRen && ((level_q != DEPTH_L) || pop);
        head_ld  = ram_vld_q && (!head_vld_q || pop);
        rd_issue = (ram_cnt_q != '0) && (!ram_vld_q || head_ld);

        wptr_d     = wptr_q + AW'(push);
        rptr_d     = rptr_q + AW'(rd_issue);
        ram_cnt_d  = ram_cnt_q + LW'(push) - LW'(rd_issue);
        level_d    = level_q + LW'(push) - LW'(pop);
        ram_vld_d  = rd_issue | (ram_vld_q & ~head_ld);
        head_vld_d = head_ld | (head_vld_q & ~pop);
        head_d     = head_ld ? dec_data : head_q;
        se_d       = head_ld ? dec_se : (se_q & ~pop);
        de_d       = head_ld ? dec_de : (de_q & ~pop);
        ovf_d      = ovf_q | (WRen & ~push);
        unf_d      = unf_q | (RDen & ~head_vld_q);
        sec_d      = sec_q + CNT_W'(pop && se_q && (sec_q != '1));
        dec_d      = dec_q + CNT_W'(pop && de_q && (dec_q != '1));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            ram_cnt_q  <= '0;
            level_q    <= '0;
            ram_vld_q  <= 1'b0;
            head_vld_q <= 1'b0;
            head_q     <= '0;
            se_q       <= 1'b0;
            de_q       <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            sec_q      <= '0;
            dec_q      <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ram_cnt_q  <= ram_cnt_d;
            level_q    <= level_d;
            ram_vld_q  <= ram_vld_d;
            head_vld_q <= head_vld_d;
            head_q     <= head_d;
            se_q       <= se_d;
            de_q       <= de_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            sec_q      <= sec_d;
            dec_q      <= dec_d;
        end
    end

    assign Empty       = ~head_vld_q;
    assign Full        = (level_q >= LW'(AFULL_LEVEL));
    assign RD          = head_q;
    assign SingleError = se_q;
    assign DoubleError = de_q;
    assign Level       = level_q;
    assign Overflow    = ovf_q;
    assign Underflow   = unf_q;
    assign SECount     = sec_q;
    assign DECount     = dec_q;
endmodule

// File: tb/tb_rb_sync_ecc.sv
// Bench for rb_sync_ecc: queue-based model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_rb_sync_ecc;
    localparam int LANES  = 2;
    localparam int LANE_W = 64;
    localparam int DEPTH  = 512;
    localparam int AFULL  = 384;
    localparam int CNT_W  = 2;
    localparam int DW     = LANES * LANE_W;
    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             WRen = 1'b0;
    logic             RDen = 1'b0;
    logic [DW-1:0]    MD = '0;
    logic [DW-1:0]    RD;
    logic             Full, Empty, SingleError, DoubleError, Overflow, Underflow;
    logic [LW-1:0]    Level;
    logic [CNT_W-1:0] SECount, DECount;
`ifdef RB_SYNC_ECC_EN
    logic [1:0]       ErrInj = 2'b00;
`endif

    always #5 Clk = ~Clk;

    rb_sync_ecc #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .MD(MD), .WRen(WRen), .Full(Full), .RD(RD), .RDen(RDen),
        .Empty(Empty), .SingleError(SingleError), .DoubleError(DoubleError), .Level(Level),
        .Overflow(Overflow), .Underflow(Underflow), .SECount(SECount), .DECount(DECount)
`ifdef RB_SYNC_ECC_EN
        , .ErrInj(ErrInj)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic cmp(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: FIFO of accepted words stamped with their push edge; a word is
    // presented once it is at the front and two edges have passed since its push.
    typedef struct {
        logic [DW-1:0] d;
        bit            se;
        bit            de;
        int            t;
    } ent_t;

    ent_t q[$];
    int   cur = 0;
    bit   m_ovf = 0, m_unf = 0, chk_en = 0;
    int   m_sec = 0, m_dec = 0;

    function automatic bit head_vis();
        return (q.size() > 0) && (q[0].t <= cur - 2);
    endfunction

    always @(posedge Clk) begin
        bit   vis, pop, push;
        ent_t e;
        vis = head_vis();
        cur++;
        if (Reset) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_sec = 0; m_dec = 0;
        end else begin
            pop  = RDen && vis;
            push = WRen && ((q.size() < DEPTH) || pop);
            if (RDen && !vis) m_unf = 1;
            if (WRen && !push) m_ovf = 1;
            if (pop) begin
                if (q[0].se && m_sec < CMAX) m_sec++;
                if (q[0].de && m_dec < CMAX) m_dec++;
                void'(q.pop_front());
            end
            if (push) begin
                e.d = MD; e.se = 0; e.de = 0; e.t = cur;
`ifdef RB_SYNC_ECC_EN
                e.se = (ErrInj == 2'b01) || (ErrInj == 2'b10);
                e.de = (ErrInj == 2'b11);
                if (e.de) e.d[1:0] = MD[1:0] ^ 2'b11;
`endif
                q.push_back(e);
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            bit vis;
            vis = head_vis();
            cmp("m_empty", DW'(Empty), DW'(!vis));
            cmp("m_level", DW'(Level), DW'(q.size()));
            cmp("m_full", DW'(Full), DW'(q.size() >= AFULL));
            cmp("m_ovf", DW'(Overflow), DW'(m_ovf));
            cmp("m_unf", DW'(Underflow), DW'(m_unf));
            cmp("m_secnt", DW'(SECount), DW'(m_sec));
            cmp("m_decnt", DW'(DECount), DW'(m_dec));
            if (vis) begin
                cmp("m_rd", RD, q[0].d);
                cmp("m_se", DW'(SingleError), DW'(q[0].se));
                cmp("m_de", DW'(DoubleError), DW'(q[0].de));
            end
        end
    end

    function automatic logic [DW-1:0] dup(input int v);
        return {64'(v), 64'(v)};
    endfunction

    function automatic logic [DW-1:0] mk(input int v);
        return {64'(v) ^ 64'hFFFF_0000_0000_0000, 64'(v)};
    endfunction

    task automatic tick(input bit wr, input bit rd, input logic [DW-1:0] d);
        WRen = wr; RDen = rd; MD = d;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick(0, 0, '0);
        Reset = 1'b0;
    endtask

    initial begin
        @(negedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        chk_en = 1;
        cmp("rst_empty", DW'(Empty), DW'(1));
        cmp("rst_full", DW'(Full), DW'(0));
        cmp("rst_level", DW'(Level), '0);
        cmp("rst_rd", RD, '0);
        cmp("rst_ovf", DW'(Overflow), DW'(0));
        cmp("rst_se", DW'(SingleError), DW'(0));
        cmp("rst_de", DW'(DoubleError), DW'(0));
        Reset = 1'b0;

        // Fill latency and FWFT order
        tick(1, 0, dup(1)); cmp("t1_empty_e0", DW'(Empty), DW'(1));
        tick(1, 0, dup(2)); cmp("t1_empty_e1", DW'(Empty), DW'(1));
        tick(1, 0, dup(3)); cmp("t1_empty_e2", DW'(Empty), DW'(0));
        cmp("t1_rd_first", RD, dup(1));
        tick(1, 0, dup(4));
        tick(0, 0, '0);     cmp("t1_level4", DW'(Level), DW'(4));
        for (int k = 1; k <= 4; k++) begin
            cmp("t1_pop_rd", RD, dup(k));
            tick(0, 1, '0);
        end
        cmp("t1_empty_end", DW'(Empty), DW'(1));
        cmp("t1_level_end", DW'(Level), DW'(0));

        // Underflow, then reset in the middle of a stream
        tick(0, 1, '0);
        cmp("t5_unf", DW'(Underflow), DW'(1));
        cmp("t5_unf_level", DW'(Level), DW'(0));
        for (int k = 0; k < 3; k++) tick(1, 0, mk(100 + k));
        do_reset();
        cmp("t5_rst_empty", DW'(Empty), DW'(1));
        cmp("t5_rst_level", DW'(Level), DW'(0));
        cmp("t5_rst_rd", RD, '0);
        cmp("t5_rst_unf", DW'(Underflow), DW'(0));
        tick(1, 0, mk(7));
        tick(0, 0, '0); cmp("t5_empty_e1", DW'(Empty), DW'(1));
        tick(0, 0, '0); cmp("t5_empty_e2", DW'(Empty), DW'(0));
        cmp("t5_sole_rd", RD, mk(7));
        cmp("t5_sole_level", DW'(Level), DW'(1));
        tick(0, 1, '0);
        cmp("t5_drained", DW'(Empty), DW'(1));

        // Fill to DEPTH, almost-full threshold
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            tick(1, 0, mk(i));
            if (i == AFULL - 2) cmp("t2_full_383", DW'(Full), DW'(0));
            if (i == AFULL - 1) cmp("t2_full_384", DW'(Full), DW'(1));
        end
        cmp("t2_level_full", DW'(Level), DW'(DEPTH));

        // Push+pop at DEPTH, then sustained streaming
        tick(1, 1, mk(DEPTH));
        cmp("t3_level_pp", DW'(Level), DW'(DEPTH));
        cmp("t3_no_ovf", DW'(Overflow), DW'(0));
        for (int k = 0; k < 1000; k++) tick(1, 1, mk(DEPTH + 1 + k));
        cmp("t3_stream_rd", RD, mk(1001));
        cmp("t3_stream_level", DW'(Level), DW'(DEPTH));

        // Overflow drop, then drain across the wrap
        tick(1, 0, mk(9999));
        cmp("t2_ovf", DW'(Overflow), DW'(1));
        cmp("t2_ovf_level", DW'(Level), DW'(DEPTH));
        for (int k = 0; k < DEPTH; k++) begin
            if (k == 0) cmp("t2_drain_first", RD, mk(1001));
            if (k == DEPTH - 1) cmp("t2_drain_last", RD, mk(1512));
            tick(0, 1, '0);
        end
        cmp("t2_drain_empty", DW'(Empty), DW'(1));
        cmp("t2_drain_level", DW'(Level), DW'(0));

        do_reset();
`ifdef RB_SYNC_ECC_EN
        ErrInj = 2'b01; tick(1, 0, dup(8'hA5)); ErrInj = 2'b00;
        tick(0, 0, '0); tick(0, 0, '0);
        cmp("t4_se_rd", RD, dup(8'hA5));
        cmp("t4_se_flag", DW'(SingleError), DW'(1));
        tick(0, 1, '0);
        cmp("t4_secnt", DW'(SECount), DW'(1));
        ErrInj = 2'b11; tick(1, 0, dup(8'hA5)); ErrInj = 2'b00;
        tick(0, 0, '0); tick(0, 0, '0);
        cmp("t4_de_rd", RD, {64'hA5, 64'hA6});
        cmp("t4_de_flag", DW'(DoubleError), DW'(1));
        cmp("t4_de_nose", DW'(SingleError), DW'(0));
        tick(0, 1, '0);
        cmp("t4_decnt", DW'(DECount), DW'(1));
        ErrInj = 2'b01;
        for (int k = 0; k < 4; k++) tick(1, 0, mk(40 + k));
        ErrInj = 2'b00;
        tick(0, 0, '0); tick(0, 0, '0);
        for (int k = 0; k < 4; k++) tick(0, 1, '0);
        cmp("t6_sat", DW'(SECount), DW'(3));
`else
        tick(1, 0, dup(8'hA5));
        tick(0, 0, '0); tick(0, 0, '0);
        cmp("t4_plain_rd", RD, dup(8'hA5));
        cmp("t4_plain_se", DW'(SingleError), DW'(0));
        tick(0, 1, '0);
        cmp("t4_plain_secnt", DW'(SECount), DW'(0));
`endif
        tick(0, 0, '0);
        tick(0, 0, '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
